axi4_slave_mem: RTL

Parametrised AXI4 slave with internal word memory; the next-generation bus endpoint of the AXI testbench environment, and the DUT-side counterpart of the `axi_if` signal set. Widens burst length to AXI4 (up to 256 beats) and parametrises ID, address and data widths and depth. Adds FIXED/INCR/WRAP address generation, byte strobes, protocol-error responses and concurrent independent read and write channels.

---
 rtl/axi4_slave_mem.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave over an internal word memory with independent read and write FSMs.
// Latency: wready 1 cycle after AW, bvalid 1 cycle after last W, rvalid 1 cycle after AR, 1 beat/cycle.
// Backpressure: valid/data/last held while ready is low; one idle cycle between bursts on each side.
// Option: define AXI_SLV_RANGE_CHK_EN to answer out-of-range word indices with DECERR.
module axi4_slave_mem #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Request-level protocol errors: oversize beat, reserved burst type, illegal wrap length.
    function automatic logic req_err(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'(LSB)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Address of the following beat; wrap spans are powers of two whenever the request is legal.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0] size,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] bytes;
        logic [ADDR_W-1:0] span;
        logic [ADDR_W-1:0] boundary;
        logic [ADDR_W-1:0] nxt;
        bytes    = ADDR_W'(1) << size;
        span     = bytes * (ADDR_W'(len) + ADDR_W'(1));
        boundary = addr & ~(span - ADDR_W'(1));
        case (burst)
            2'b01:   nxt = addr + bytes;
            2'b10:   nxt = boundary + ((addr + bytes - boundary) & (span - ADDR_W'(1)));
            default: nxt = addr;
        endcase
        return nxt;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------ write side
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    w_state_e w_state_q, w_state_d;

    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [7:0]        w_len_q, w_cnt_q;
    logic [2:0]        w_size_q;
    logic [1:0]        w_burst_q;
    logic              w_err_q, w_dec_q;

    logic aw_hs, w_hs, b_hs, w_last_beat, w_beat_err, w_oor, w_we;
    logic [IDX_W-1:0] w_idx;

    assign aw_hs       = awvalid & awready_q;
    assign w_hs        = wvalid & wready_q;
    assign b_hs        = bvalid_q & bready;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_beat_err  = (wlast != w_last_beat);
    assign w_idx       = w_addr_q[IDX_W+LSB-1:LSB];
    assign w_we        = w_hs & ~w_err_q & ~w_beat_err & ~w_oor;

    // Write FSM next state: accept address, take len+1 beats, hold response until taken.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs, decoded from the next state so they come straight out of flops.
    always_comb begin
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write FSM state and registered handshake outputs; ready stays low during reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Write burst context: latched request, beat walk, sticky error flags and final response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_dec_q   <= 1'b0;
        end else if (aw_hs) begin
            bid_q     <= awid;
            w_addr_q  <= awaddr;
            w_len_q   <= awlen;
            w_cnt_q   <= '0;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            w_err_q   <= req_err(awsize, awlen, awburst);
            w_dec_q   <= 1'b0;
        end else if (w_hs) begin
            w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
            w_cnt_q  <= w_cnt_q + 8'd1;
            if (w_beat_err) w_err_q <= 1'b1;
            if (w_oor)      w_dec_q <= 1'b1;
            if (w_last_beat) begin
                bresp_q <= (w_err_q || w_beat_err) ? RESP_SLVERR :
                           (w_dec_q || w_oor)      ? RESP_DECERR : RESP_OKAY;
            end
        end
    end

    // Byte-lane writes into the word array; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------ read side
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    r_state_e r_state_q, r_state_d;

    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic [ADDR_W-1:0] r_addr_q, r_addr_nxt;
    logic [7:0]        r_len_q, r_cnt_q;
    logic [2:0]        r_size_q;
    logic [1:0]        r_burst_q;
    logic              r_err_q;

    logic ar_hs, r_hs, ar_err, ar_oor, rn_oor;
    logic [IDX_W-1:0] ar_idx, rn_idx;

    assign ar_hs      = arvalid & arready_q;
    assign r_hs       = rvalid_q & rready;
    assign ar_err     = req_err(arsize, arlen, arburst);
    assign r_addr_nxt = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
    assign ar_idx     = araddr[IDX_W+LSB-1:LSB];
    assign rn_idx     = r_addr_nxt[IDX_W+LSB-1:LSB];

`ifdef AXI_SLV_RANGE_CHK_EN
    assign w_oor  = |w_addr_q[ADDR_W-1:IDX_W+LSB];
    assign ar_oor = |araddr[ADDR_W-1:IDX_W+LSB];
    assign rn_oor = |r_addr_nxt[ADDR_W-1:IDX_W+LSB];
`else
    assign w_oor  = 1'b0;
    assign ar_oor = 1'b0;
    assign rn_oor = 1'b0;
`endif

    // Read FSM next state: one request in flight, leave after the rlast beat is taken.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs, decoded from the next state.
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // Read FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Read burst context: prefetch the first word on AR, the next word on each accepted beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
        end else if (ar_hs) begin
            rid_q     <= arid;
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_cnt_q   <= '0;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            r_err_q   <= ar_err;
            rlast_q   <= (arlen == 8'd0);
            rdata_q   <= (ar_err || ar_oor) ? '0 : mem_q[ar_idx];
            rresp_q   <= ar_err ? RESP_SLVERR : (ar_oor ? RESP_DECERR : RESP_OKAY);
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                r_addr_q <= r_addr_nxt;
                r_cnt_q  <= r_cnt_q + 8'd1;
                rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
                rdata_q  <= (r_err_q || rn_oor) ? '0 : mem_q[rn_idx];
                rresp_q  <= r_err_q ? RESP_SLVERR : (rn_oor ? RESP_DECERR : RESP_OKAY);
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule
